// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Purpose : PC owner and instruction fetch over req/ready/rvalid; optional
//           fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_req,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        instr_valid,
  output logic        busy,
  output logic        misaligned,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pending;
  logic [31:0] r_pending_pc;
  logic        w_start;
  logic        w_complete;
  logic        w_misalign;
  logic        w_abort;
  logic        w_timeout_hit;
  logic [1:0]  w_fetch_lsb;

  assign busy     = (r_state != S_IDLE);
  assign mem_req  = (r_state == S_REQ);
  assign mem_addr = pc;
  assign op       = instr[6:0];
  assign funct3   = instr[14:12];

  // A simultaneous pc_we in IDLE redirects the fetch, so alignment is judged on the new PC.
  assign w_fetch_lsb = pc_we ? pc_next[1:0] : pc[1:0];

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_misalign   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_req) begin
          if (w_fetch_lsb != 2'b00) begin
            w_misalign = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (mem_rvalid) begin
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout_hit && !w_complete) begin
      w_abort      = 1'b1;
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      pc           <= RESET_PC;
      old_pc       <= RESET_PC;
      instr        <= RESET_INSTR;
      instr_valid  <= 1'b0;
      misaligned   <= 1'b0;
      r_pending    <= 1'b0;
      r_pending_pc <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      instr_valid <= w_complete;
      misaligned  <= w_misalign;
      if (w_complete) begin
        instr     <= mem_rdata;
        old_pc    <= pc;
        r_pending <= 1'b0;
        // A redirect on the completing edge is the most recent write, so it wins.
        if (pc_we)          pc <= pc_next;
        else if (r_pending) pc <= r_pending_pc;
        else                pc <= pc + 32'd4;
      end else if (!busy) begin
        if (pc_we) pc <= pc_next;
      end else if (w_abort) begin
        r_pending <= 1'b0;
      end else if (pc_we) begin
        r_pending    <= 1'b1;
        r_pending_pc <= pc_next;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_fault;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wd_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (w_start)   r_wd_cnt <= '0;
      else if (busy) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_abort)   r_fault  <= 1'b1;
    end
  end

  // Count equals cycles already spent busy, so this fires on the last allowed cycle.
  assign w_timeout_hit = busy && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fault         = r_fault;
`else
  assign w_timeout_hit = 1'b0;
  assign fault         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: table-driven vectors plus multi-cycle sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_req;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        instr_valid;
  logic        busy;
  logic        misaligned;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit dut (
    .clk(clk), .resetn(resetn), .fetch_req(fetch_req), .pc_we(pc_we), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .pc(pc), .old_pc(old_pc), .instr(instr), .op(op), .funct3(funct3),
    .instr_valid(instr_valid), .busy(busy), .misaligned(misaligned), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        fetch_req;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_busy;
    logic [31:0] e_pc;
    logic [31:0] e_old_pc;
    logic [31:0] e_instr;
    logic        e_iv;
    logic        e_mis;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    pc_we      = 1'b0;
    pc_next    = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  req_cycles;
    bit  addr_ok;
    bit  done;
    int  k;

    //           name        freq we  pc_next       rdy rv  rdata          mreq busy pc            old_pc        instr         iv mis
    vecs[0]  = '{"zw_start",  1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        32'h0,        32'h13,       0, 0};
    vecs[1]  = '{"zw_done",   0, 0, 32'h0,        1, 1, 32'h2083,     0, 0, 32'h4,        32'h0,        32'h2083,     1, 0};
    vecs[2]  = '{"zw_after",  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        32'h2083,     0, 0};
    vecs[3]  = '{"pcw_102",   0, 1, 32'h102,      0, 0, 32'h0,        0, 0, 32'h102,      32'h0,        32'h2083,     0, 0};
    vecs[4]  = '{"mis_pulse", 1, 0, 32'h0,        1, 1, 32'h0,        0, 0, 32'h102,      32'h0,        32'h2083,     0, 1};
    vecs[5]  = '{"mis_clear", 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h102,      32'h0,        32'h2083,     0, 0};
    vecs[6]  = '{"we_fetch",  1, 1, 32'hFFFF_FFFC,0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC,32'h0,        32'h2083,     0, 0};
    vecs[7]  = '{"to_wait",   0, 0, 32'h0,        1, 0, 32'h0,        0, 1, 32'hFFFF_FFFC,32'h0,        32'h2083,     0, 0};
    vecs[8]  = '{"busy_freq", 1, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC,32'h0,        32'h2083,     0, 0};
    vecs[9]  = '{"wrap_done", 0, 0, 32'h0,        0, 1, 32'h0040_006F,0, 0, 32'h0,        32'hFFFF_FFFC,32'h0040_006F,1, 0};
    vecs[10] = '{"wrap_idle", 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFC,32'h0040_006F,0, 0};

    // Reset held two edges
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    chk("rst_pc",     pc,          32'h0);
    chk("rst_instr",  instr,       32'h13);
    chk("rst_op",     {25'h0, op}, 32'h13);
    chk("rst_mem_req",{31'h0, mem_req},     32'h0);
    chk("rst_iv",     {31'h0, instr_valid}, 32'h0);
    chk("rst_busy",   {31'h0, busy},        32'h0);
    chk("rst_fault",  {31'h0, fault},       32'h0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      fetch_req  = vecs[i].fetch_req;
      pc_we      = vecs[i].pc_we;
      pc_next    = vecs[i].pc_next;
      mem_ready  = vecs[i].mem_ready;
      mem_rvalid = vecs[i].mem_rvalid;
      mem_rdata  = vecs[i].mem_rdata;
      step();
      chk({vecs[i].name, "_mem_req"}, {31'h0, mem_req},     {31'h0, vecs[i].e_mem_req});
      chk({vecs[i].name, "_busy"},    {31'h0, busy},        {31'h0, vecs[i].e_busy});
      chk({vecs[i].name, "_pc"},      pc,                   vecs[i].e_pc);
      chk({vecs[i].name, "_addr"},    mem_addr,             vecs[i].e_pc);
      chk({vecs[i].name, "_old_pc"},  old_pc,               vecs[i].e_old_pc);
      chk({vecs[i].name, "_instr"},   instr,                vecs[i].e_instr);
      chk({vecs[i].name, "_iv"},      {31'h0, instr_valid}, {31'h0, vecs[i].e_iv});
      chk({vecs[i].name, "_mis"},     {31'h0, misaligned},  {31'h0, vecs[i].e_mis});
      chk({vecs[i].name, "_op"},      {25'h0, op},          {25'h0, vecs[i].e_instr[6:0]});
      chk({vecs[i].name, "_funct3"},  {29'h0, funct3},      {29'h0, vecs[i].e_instr[14:12]});
    end
    idle_inputs();
    chk("lw_funct3_direct", {29'h0, vecs[1].e_instr[14:12]}, 32'h2);

    // Wait states: ready on third REQ cycle, rvalid three cycles later
    fetch_req = 1'b1;
    step();
    fetch_req  = 1'b0;
    req_cycles = 0;
    addr_ok    = 1'b1;
    done       = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mem_req) req_cycles++;
      if (busy && (mem_addr !== 32'h0 || pc !== 32'h0)) addr_ok = 1'b0;
      mem_ready  = (i == 2);
      mem_rvalid = (i == 5);
      mem_rdata  = 32'h0000_4503;
      step();
      if (instr_valid) done = 1'b1;
    end
    idle_inputs();
    chk("ws_done",       {31'h0, done},    32'h1);
    chk("ws_req_cycles", req_cycles,       32'd3);
    chk("ws_addr_stable",{31'h0, addr_ok}, 32'h1);
    chk("ws_pc",         pc,               32'h4);
    chk("ws_old_pc",     old_pc,           32'h0);
    chk("ws_instr",      instr,            32'h0000_4503);
    step();
    chk("ws_iv_one_cycle", {31'h0, instr_valid}, 32'h0);

    // Redirect during WAIT, last write wins
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    pc_we     = 1'b1;
    pc_next   = 32'h200;
    step();
    chk("rd_pc_hold1", pc, 32'h4);
    pc_next = 32'h100;
    step();
    chk("rd_pc_hold2", pc, 32'h4);
    chk("rd_busy",     {31'h0, busy}, 32'h1);
    pc_we      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0063;
    step();
    idle_inputs();
    chk("rd_pc",     pc,     32'h100);
    chk("rd_old_pc", old_pc, 32'h4);
    chk("rd_iv",     {31'h0, instr_valid}, 32'h1);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("rd_next_req",  {31'h0, mem_req}, 32'h1);
    chk("rd_next_addr", mem_addr, 32'h100);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0033;
    step();
    idle_inputs();
    chk("rd_next_pc", pc, 32'h104);

    // Reset mid-fetch, then a late rvalid
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    resetn    = 1'b0;
    step();
    resetn     = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    chk("rm_busy",  {31'h0, busy},        32'h0);
    chk("rm_instr", instr,                32'h13);
    chk("rm_pc",    pc,                   32'h0);
    chk("rm_iv",    {31'h0, instr_valid}, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: ready accepted, rvalid never arrives
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step();
      mem_ready = 1'b0;
      if (fault) k = i;
    end
    chk("to_cycles",  k,                  32'd16);
    chk("to_mem_req", {31'h0, mem_req},   32'h0);
    chk("to_busy",    {31'h0, busy},      32'h0);
    chk("to_instr",   instr,              32'h13);
    chk("to_pc",      pc,                 32'h0);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("to_refetch", {31'h0, mem_req},   32'h1);
    chk("to_sticky",  {31'h0, fault},     32'h1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("to_cleared", {31'h0, fault},     32'h0);
`else
    // Without the watchdog a stalled fetch waits indefinitely
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("nto_busy",  {31'h0, busy},  32'h1);
    chk("nto_fault", {31'h0, fault}, 32'h0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
